// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding controller sitting beside ID. Tracks the destination
// register of each in-flight writer for NUM_STAGES stages after ID, picks a
// forward source per read port, raises a load-use stall and counts stall cycles.
module hazard_scoreboard #(
  parameter int NUM_STAGES     = 3,
  parameter int REG_ADDR_W     = 5,
  parameter int NUM_READ_PORTS = 2,
  parameter int LOAD_STAGE     = 2,
  parameter int CNT_W          = 16,
  localparam int SEL_W         = $clog2(NUM_STAGES + 1)
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic                                 i_stall,
  input  logic                                 i_flush,
  input  logic                                 i_issue_valid,
  input  logic                                 i_issue_wr,
  input  logic                                 i_issue_load,
  input  logic [REG_ADDR_W-1:0]                i_issue_rd,
  input  logic [NUM_READ_PORTS*REG_ADDR_W-1:0] i_rs,
  input  logic [NUM_READ_PORTS-1:0]            i_rs_used,
  output logic                                 o_hazard,
  output logic [NUM_READ_PORTS*SEL_W-1:0]      o_fwd_sel,
  output logic [NUM_STAGES-1:0]                o_stage_valid,
  output logic [CNT_W-1:0]                     o_stall_cnt
);

  // Index k-1 holds stage k (stage 1 = ID/EX).
  logic [NUM_STAGES-1:0] valid_q;
  logic [NUM_STAGES-1:0] load_q;
  logic [REG_ADDR_W-1:0] rd_q [NUM_STAGES];
  logic [CNT_W-1:0]      cnt_q;

  logic [NUM_READ_PORTS-1:0] load_use;
  logic                      enter;

  // Forward select and load-use per port. Oldest stage is scanned first so the
  // youngest matching stage overwrites it and wins.
  always_comb begin
    o_fwd_sel = '0;
    load_use  = '0;
    for (int p = 0; p < NUM_READ_PORTS; p++) begin
      for (int k = NUM_STAGES - 1; k >= 0; k--) begin
        if (i_rs_used[p] && (i_rs[p*REG_ADDR_W +: REG_ADDR_W] != '0) &&
            valid_q[k] && (rd_q[k] == i_rs[p*REG_ADDR_W +: REG_ADDR_W])) begin
          o_fwd_sel[p*SEL_W +: SEL_W] = SEL_W'(k + 1);
          load_use[p]                 = load_q[k] && ((k + 1) < LOAD_STAGE);
        end
      end
    end
  end

  // Stall only a live, unflushed ID instruction; a flushed one must not enter either.
  always_comb begin
    o_hazard = (|load_use) && i_issue_valid && !i_flush;
    enter    = i_issue_valid && i_issue_wr && (i_issue_rd != '0) && !o_hazard && !i_flush;
  end

  // Advance the tracked writers and the saturating stall counter; freeze on i_stall.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= '0;
      load_q  <= '0;
      for (int k = 0; k < NUM_STAGES; k++) rd_q[k] <= '0;
      cnt_q   <= '0;
    end else if (!i_stall) begin
      for (int k = NUM_STAGES - 1; k >= 1; k--) begin
        valid_q[k] <= valid_q[k-1];
        load_q[k]  <= load_q[k-1];
        rd_q[k]    <= rd_q[k-1];
      end
      valid_q[0] <= enter;
      load_q[0]  <= enter && i_issue_load;
      rd_q[0]    <= i_issue_rd;
      if (o_hazard && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign o_stage_valid = valid_q;
  assign o_stall_cnt   = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: stimulus queues hand-computed
// expectations, a negedge monitor pops and compares them. A second instance
// with a 2-bit counter shares the stimulus to exercise saturation.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst, stall, flush, issue_valid, issue_wr, issue_load;
  logic [4:0] issue_rd;
  logic [9:0] rs;
  logic [1:0] rs_used;

  logic        hazard, hazard2;
  logic [3:0]  fwd_sel, fwd_sel2;
  logic [2:0]  stage_valid, stage_valid2;
  logic [15:0] stall_cnt;
  logic [1:0]  stall_cnt2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic        haz;
    logic [3:0]  sel;
    logic [2:0]  sv;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] exp_cnt;
  logic [1:0]  exp_cnt2;

  hazard_scoreboard dut (
    .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_flush(flush),
    .i_issue_valid(issue_valid), .i_issue_wr(issue_wr), .i_issue_load(issue_load),
    .i_issue_rd(issue_rd), .i_rs(rs), .i_rs_used(rs_used),
    .o_hazard(hazard), .o_fwd_sel(fwd_sel), .o_stage_valid(stage_valid),
    .o_stall_cnt(stall_cnt)
  );

  hazard_scoreboard #(.CNT_W(2)) dut_small (
    .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_flush(flush),
    .i_issue_valid(issue_valid), .i_issue_wr(issue_wr), .i_issue_load(issue_load),
    .i_issue_rd(issue_rd), .i_rs(rs), .i_rs_used(rs_used),
    .o_hazard(hazard2), .o_fwd_sel(fwd_sel2), .o_stage_valid(stage_valid2),
    .o_stall_cnt(stall_cnt2)
  );

  always #5 clk = ~clk;

  // Monitor: compare the DUT against the expectation queued for this cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (hazard !== e.haz) begin
        errors++;
        $display("FAIL %s hazard got %0b expected %0b", e.name, hazard, e.haz);
      end
      checks++;
      if (fwd_sel !== e.sel) begin
        errors++;
        $display("FAIL %s fwd_sel got %b expected %b", e.name, fwd_sel, e.sel);
      end
      checks++;
      if (stage_valid !== e.sv) begin
        errors++;
        $display("FAIL %s stage_valid got %b expected %b", e.name, stage_valid, e.sv);
      end
      checks++;
      if (stall_cnt !== e.cnt) begin
        errors++;
        $display("FAIL %s stall_cnt got %0d expected %0d", e.name, stall_cnt, e.cnt);
      end
      checks++;
      if (stall_cnt2 !== e.cnt2) begin
        errors++;
        $display("FAIL %s stall_cnt_w2 got %0d expected %0d", e.name, stall_cnt2, e.cnt2);
      end
    end
  end

  task automatic step(input string name, input logic v, input logic wr, input logic ld,
                      input logic [4:0] rd, input logic [4:0] rs0, input logic [4:0] rs1,
                      input logic [1:0] used, input logic stl, input logic fl,
                      input logic e_haz, input logic [3:0] e_sel, input logic [2:0] e_sv);
    exp_t e;
    issue_valid = v;
    issue_wr    = wr;
    issue_load  = ld;
    issue_rd    = rd;
    rs          = {rs1, rs0};
    rs_used     = used;
    stall       = stl;
    flush       = fl;
    e.name = name;
    e.haz  = e_haz;
    e.sel  = e_sel;
    e.sv   = e_sv;
    e.cnt  = exp_cnt;
    e.cnt2 = exp_cnt2;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (e_haz && !stl) begin
      exp_cnt = exp_cnt + 16'd1;
      if (exp_cnt2 != 2'd3) exp_cnt2 = exp_cnt2 + 2'd1;
    end
  endtask

  task automatic idle(input string name, input logic [2:0] e_sv);
    step(name, 0, 0, 0, 5'd0, 5'd0, 5'd0, 2'b00, 0, 0, 0, 4'b0000, e_sv);
  endtask

  initial begin
    exp_cnt  = '0;
    exp_cnt2 = '0;

    // Reset for two cycles with random inputs
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      stall       = 1'($urandom);
      flush       = 1'($urandom);
      issue_valid = 1'($urandom);
      issue_wr    = 1'($urandom);
      issue_load  = 1'($urandom);
      issue_rd    = 5'($urandom);
      rs          = 10'($urandom);
      rs_used     = 2'($urandom);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    idle("rst_idle", 3'b000);

    // ALU chain: forward from stage 1, 2, 3, then register file
    step("alu_issue",   1, 1, 0, 5'd5, 5'd0, 5'd0, 2'b00, 0, 0, 0, 4'b0000, 3'b000);
    step("alu_fwd1",    1, 1, 0, 5'd6, 5'd5, 5'd0, 2'b01, 0, 0, 0, 4'b0001, 3'b001);
    step("alu_fwd2",    0, 0, 0, 5'd0, 5'd5, 5'd0, 2'b01, 0, 0, 0, 4'b0010, 3'b011);
    step("alu_fwd3",    0, 0, 0, 5'd0, 5'd5, 5'd0, 2'b01, 0, 0, 0, 4'b0011, 3'b110);
    step("alu_retired", 0, 0, 0, 5'd0, 5'd5, 5'd0, 2'b01, 0, 0, 0, 4'b0000, 3'b100);
    step("alu_empty",   0, 0, 0, 5'd0, 5'd5, 5'd0, 2'b01, 0, 0, 0, 4'b0000, 3'b000);

    // Load-use on port 1
    step("lw_issue", 1, 1, 1, 5'd8, 5'd0, 5'd0, 2'b00, 0, 0, 0, 4'b0000, 3'b000);
    step("lw_use",   1, 1, 0, 5'd9, 5'd0, 5'd8, 2'b10, 0, 0, 1, 4'b0100, 3'b001);
    step("lw_fwd2",  1, 1, 0, 5'd9, 5'd0, 5'd8, 2'b10, 0, 0, 0, 4'b1000, 3'b010);
    idle("lw_drain0", 3'b101);
    idle("lw_drain1", 3'b010);
    idle("lw_drain2", 3'b100);

    // Youngest writer wins; r0 never matches and rd=0 never enters
    step("yw_a",      1, 1, 0, 5'd3, 5'd0, 5'd0, 2'b00, 0, 0, 0, 4'b0000, 3'b000);
    step("yw_b",      1, 1, 0, 5'd3, 5'd0, 5'd0, 2'b00, 0, 0, 0, 4'b0000, 3'b001);
    step("yw_read",   0, 0, 0, 5'd0, 5'd3, 5'd0, 2'b11, 0, 0, 0, 4'b0001, 3'b011);
    step("rd0_issue", 1, 1, 0, 5'd0, 5'd3, 5'd0, 2'b01, 0, 0, 0, 4'b0010, 3'b110);
    step("r0_read",   0, 0, 0, 5'd0, 5'd0, 5'd0, 2'b01, 0, 0, 0, 4'b0000, 3'b100);
    idle("yw_empty", 3'b000);

    // Flush beats hazard
    step("fl_load", 1, 1, 1, 5'd4, 5'd0, 5'd0, 2'b00, 0, 0, 0, 4'b0000, 3'b000);
    step("fl_use",  1, 1, 0, 5'd7, 5'd4, 5'd0, 2'b01, 0, 1, 0, 4'b0001, 3'b001);
    idle("fl_drain0", 3'b010);
    idle("fl_drain1", 3'b100);

    // Global stall freezes entries and counter; flush ignored while stalled
    step("st_alu", 1, 1, 0, 5'd10, 5'd0, 5'd0, 2'b00, 0, 0, 0, 4'b0000, 3'b000);
    step("st_lw",  1, 1, 1, 5'd11, 5'd0, 5'd0, 2'b00, 0, 0, 0, 4'b0000, 3'b001);
    for (int i = 0; i < 5; i++) begin
      step("st_hold", 1, 1, 0, 5'd12, 5'd11, 5'd0, 2'b01, 1, (i == 2), (i != 2), 4'b0001, 3'b011);
    end
    step("st_release", 1, 1, 0, 5'd12, 5'd11, 5'd0, 2'b01, 0, 0, 1, 4'b0001, 3'b011);
    step("st_fwd2",    1, 1, 0, 5'd12, 5'd11, 5'd0, 2'b01, 0, 0, 0, 4'b0010, 3'b110);
    idle("st_drain0", 3'b101);
    idle("st_drain1", 3'b010);
    idle("st_drain2", 3'b100);

    // Five more hazard cycles: the 2-bit counter saturates at 3
    for (int i = 0; i < 5; i++) begin
      step("sat_ld",  1, 1, 1, 5'd4, 5'd0, 5'd0, 2'b00, 0, 0, 0, 4'b0000,
           (i == 0) ? 3'b000 : 3'b010);
      step("sat_use", 1, 0, 0, 5'd0, 5'd4, 5'd0, 2'b01, 0, 0, 1, 4'b0001,
           (i == 0) ? 3'b001 : 3'b101);
    end
    idle("sat_final", 3'b010);

    // Reset mid-operation overrides stall
    step("pre_rst", 1, 1, 0, 5'd13, 5'd0, 5'd0, 2'b00, 0, 0, 0, 4'b0000, 3'b100);
    rst         = 1'b1;
    stall       = 1'b1;
    flush       = 1'b1;
    issue_valid = 1'b1;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    exp_cnt  = '0;
    exp_cnt2 = '0;
    idle("post_rst", 3'b000);

    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
